// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage with multiple outstanding requests on an SRAM-like
// req/addr_ok/data_ok port. Returned instructions are buffered in a small
// queue in front of ID. Redirects flush the queue and turn every response
// still in flight into a stale one that is silently dropped on return.
module if_prefetch_stage #(
  parameter int          OUTSTANDING = 2,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] RESET_PC    = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_stall,
  input  logic        id_allowin,
  output logic        if_id_valid,
  output logic [64:0] if_id_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int QAW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TAW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int IFW  = 3;

  localparam logic [IFW-1:0]  OUT_L    = IFW'(OUTSTANDING);
  localparam logic [7:0]      DEPTH_L  = 8'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] FULL_L   = CNTW'(FIFO_DEPTH);
  localparam logic [QAW-1:0]  Q_LAST   = QAW'(FIFO_DEPTH - 1);
  localparam logic [TAW-1:0]  T_LAST   = TAW'(OUTSTANDING - 1);

  // Architectural fetch state
  logic [31:0]     fetch_pc_r;
  logic [IFW-1:0]  inflight_r;
  logic [IFW-1:0]  discard_r;
  logic            adef_pending_r;

  // pc tag queue: one entry per accepted-but-unreturned request
  logic [31:0]     tag_mem_r [OUTSTANDING];
  logic [TAW-1:0]  tag_wr_r;
  logic [TAW-1:0]  tag_rd_r;

  // Instruction queue towards ID
  logic [64:0]     q_mem_r [FIFO_DEPTH];
  logic [QAW-1:0]  q_wr_r;
  logic [QAW-1:0]  q_rd_r;
  logic [CNTW-1:0] count_r;

  logic [7:0]      owed_s;
  logic            req_s;
  logic            accept_s;
  logic            live_resp_s;
  logic            adef_push_s;
  logic            q_push_s;
  logic            q_pop_s;
  logic [64:0]     q_push_data_s;

  // Request gating: only fetch when every live response already owns a queue slot
  always_comb begin
    owed_s = 8'(inflight_r) - 8'(discard_r) + 8'(count_r);
    req_s  = resetn & ~redirect_valid & ~fetch_stall & ~adef_pending_r &
             (fetch_pc_r[1:0] == 2'b00) & (inflight_r < OUT_L) & (owed_s < DEPTH_L);
  end

  // Per-cycle events: accept, live response, address-error entry, queue push/pop
  always_comb begin
    accept_s    = req_s & inst_sram_addr_ok;
    live_resp_s = inst_sram_data_ok & (discard_r == {IFW{1'b0}}) & ~redirect_valid;
    adef_push_s = ~redirect_valid & (fetch_pc_r[1:0] != 2'b00) & ~adef_pending_r &
                  (inflight_r == discard_r) & (count_r != FULL_L);
    q_push_s    = live_resp_s | adef_push_s;
    q_pop_s     = (count_r != {CNTW{1'b0}}) & id_allowin & ~redirect_valid;
    if (live_resp_s) begin
      q_push_data_s = {1'b0, inst_sram_rdata, tag_mem_r[tag_rd_r]};
    end else begin
      q_push_data_s = {1'b1, 32'h0000_0000, fetch_pc_r};
    end
  end

  // Fetch pc, in-flight and stale-response counters, address-error latch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_r     <= RESET_PC;
      inflight_r     <= {IFW{1'b0}};
      discard_r      <= {IFW{1'b0}};
      adef_pending_r <= 1'b0;
    end else begin
      case ({accept_s, inst_sram_data_ok})
        2'b10:   inflight_r <= inflight_r + 3'd1;
        2'b01:   inflight_r <= inflight_r - 3'd1;
        default: inflight_r <= inflight_r;
      endcase
      if (redirect_valid) begin
        // everything still outstanding after this cycle's return is stale
        fetch_pc_r     <= redirect_pc;
        discard_r      <= inflight_r - {2'b00, inst_sram_data_ok};
        adef_pending_r <= 1'b0;
      end else begin
        if (accept_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end else begin
          fetch_pc_r <= fetch_pc_r;
        end
        if (inst_sram_data_ok && (discard_r != {IFW{1'b0}})) begin
          discard_r <= discard_r - 3'd1;
        end else begin
          discard_r <= discard_r;
        end
        if (adef_push_s) begin
          adef_pending_r <= 1'b1;
        end else begin
          adef_pending_r <= adef_pending_r;
        end
      end
    end
  end

  // pc tag queue: push on accept, pop on every response (stale or live)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_wr_r <= {TAW{1'b0}};
      tag_rd_r <= {TAW{1'b0}};
      for (int i = 0; i < OUTSTANDING; i++) begin
        tag_mem_r[i] <= 32'h0000_0000;
      end
    end else begin
      if (accept_s) begin
        tag_mem_r[tag_wr_r] <= fetch_pc_r;
        tag_wr_r <= (tag_wr_r == T_LAST) ? {TAW{1'b0}} : tag_wr_r + 1'b1;
      end else begin
        tag_wr_r <= tag_wr_r;
      end
      if (inst_sram_data_ok) begin
        tag_rd_r <= (tag_rd_r == T_LAST) ? {TAW{1'b0}} : tag_rd_r + 1'b1;
      end else begin
        tag_rd_r <= tag_rd_r;
      end
    end
  end

  // Instruction queue: flushed by redirect, otherwise push/pop with occupancy count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_wr_r  <= {QAW{1'b0}};
      q_rd_r  <= {QAW{1'b0}};
      count_r <= {CNTW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_mem_r[i] <= 65'h0;
      end
    end else if (redirect_valid) begin
      q_wr_r  <= {QAW{1'b0}};
      q_rd_r  <= {QAW{1'b0}};
      count_r <= {CNTW{1'b0}};
    end else begin
      if (q_push_s) begin
        q_mem_r[q_wr_r] <= q_push_data_s;
        q_wr_r <= (q_wr_r == Q_LAST) ? {QAW{1'b0}} : q_wr_r + 1'b1;
      end else begin
        q_wr_r <= q_wr_r;
      end
      if (q_pop_s) begin
        q_rd_r <= (q_rd_r == Q_LAST) ? {QAW{1'b0}} : q_rd_r + 1'b1;
      end else begin
        q_rd_r <= q_rd_r;
      end
      case ({q_push_s, q_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Output drive: ID side comes straight from queue registers
  always_comb begin
    if_id_valid     = (count_r != {CNTW{1'b0}});
    if (if_id_valid) begin
      if_id_bus = q_mem_r[q_rd_r];
    end else begin
      if_id_bus = 65'h0;
    end
    inst_sram_req   = req_s;
    inst_sram_addr  = fetch_pc_r;
    inst_sram_wr    = 1'b0;
    inst_sram_size  = 2'b10;
    inst_sram_wstrb = 4'h0;
    inst_sram_wdata = 32'h0000_0000;
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed cycle-by-cycle vectors for if_prefetch_stage. Memory handshakes
// are driven straight from the table; expected outputs are hand-computed.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_stall;
  logic        id_allowin;
  logic        if_id_valid;
  logic [64:0] if_id_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  int n_vec = 0;
  int n_err = 0;

  if_prefetch_stage dut (
    .clk(clk), .resetn(resetn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_stall(fetch_stall), .id_allowin(id_allowin),
    .if_id_valid(if_id_valid), .if_id_bus(if_id_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        st;
    logic        al;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [64:0] e_bus;
  } vec_t;

  localparam int NV = 37;
  vec_t vt [NV];

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic st,
                              input logic al, input logic aok, input logic dok,
                              input logic [31:0] rd, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [64:0] eb);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.st = st; v.al = al; v.aok = aok; v.dok = dok; v.rd = rd;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_bus = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic er, input logic [31:0] ea,
                     input logic ev, input logic [64:0] eb);
    n_vec++;
    if (inst_sram_req !== er) begin
      n_err++;
      $display("FAIL %s req: got %0b want %0b", nm, inst_sram_req, er);
    end
    if (inst_sram_addr !== ea) begin
      n_err++;
      $display("FAIL %s addr: got %h want %h", nm, inst_sram_addr, ea);
    end
    if (if_id_valid !== ev) begin
      n_err++;
      $display("FAIL %s valid: got %0b want %0b", nm, if_id_valid, ev);
    end
    if (if_id_bus !== eb) begin
      n_err++;
      $display("FAIL %s bus: got %h want %h", nm, if_id_bus, eb);
    end
    if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
      n_err++;
      $display("FAIL %s const: got %b/%b/%h/%h", nm, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
    end
  endtask

  initial begin
    // streaming fetch, responses in order
    vt[0]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_0000, 1'b0, 65'h0);
    vt[1]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_0004, 1'b0, 65'h0);
    vt[2]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD0D0_0000, 1'b0, 32'h1C00_0008, 1'b0, 65'h0);
    vt[3]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_0008, 1'b1, {1'b0, 32'hD0D0_0000, 32'h1C00_0000});
    vt[4]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD0D0_0004, 1'b0, 32'h1C00_000C, 1'b0, 65'h0);
    vt[5]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD0D0_0008, 1'b1, 32'h1C00_000C, 1'b1, {1'b0, 32'hD0D0_0004, 32'h1C00_0004});
    // ID back-pressure: queue fills to 4 and request stops while 4 are owed
    vt[6]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_0010, 1'b1, {1'b0, 32'hD0D0_0008, 32'h1C00_0008});
    vt[7]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hD0D0_000C, 1'b0, 32'h1C00_0014, 1'b1, {1'b0, 32'hD0D0_0008, 32'h1C00_0008});
    vt[8]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hD0D0_0010, 1'b1, 32'h1C00_0014, 1'b1, {1'b0, 32'hD0D0_0008, 32'h1C00_0008});
    vt[9]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h1C00_0018, 1'b1, {1'b0, 32'hD0D0_0008, 32'h1C00_0008});
    vt[10] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hD0D0_0014, 1'b0, 32'h1C00_0018, 1'b1, {1'b0, 32'hD0D0_0008, 32'h1C00_0008});
    vt[11] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h1C00_0018, 1'b1, {1'b0, 32'hD0D0_0008, 32'h1C00_0008});
    vt[12] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h1C00_0018, 1'b1, {1'b0, 32'hD0D0_0008, 32'h1C00_0008});
    vt[13] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_0018, 1'b1, {1'b0, 32'hD0D0_000C, 32'h1C00_000C});
    vt[14] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1C00_001C, 1'b1, {1'b0, 32'hD0D0_0010, 32'h1C00_0010});
    vt[15] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_001C, 1'b1, {1'b0, 32'hD0D0_0014, 32'h1C00_0014});
    // redirect with two in flight: both returns dropped
    vt[16] = mk(1'b1, 32'h1C00_0100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h1C00_0020, 1'b0, 65'h0);
    vt[17] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD0D0_0018, 1'b0, 32'h1C00_0100, 1'b0, 65'h0);
    vt[18] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD0D0_001C, 1'b1, 32'h1C00_0100, 1'b0, 65'h0);
    vt[19] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hD0D0_0100, 1'b1, 32'h1C00_0104, 1'b0, 65'h0);
    vt[20] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_0104, 1'b1, {1'b0, 32'hD0D0_0100, 32'h1C00_0100});
    // redirect coinciding with a return while two are in flight
    vt[21] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_0108, 1'b0, 65'h0);
    vt[22] = mk(1'b1, 32'h1C00_0200, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD0D0_0104, 1'b0, 32'h1C00_010C, 1'b0, 65'h0);
    vt[23] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD0D0_0108, 1'b1, 32'h1C00_0200, 1'b0, 65'h0);
    vt[24] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hD0D0_0200, 1'b1, 32'h1C00_0204, 1'b0, 65'h0);
    vt[25] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1C00_0204, 1'b1, {1'b0, 32'hD0D0_0200, 32'h1C00_0200});
    // stall suppresses request
    vt[26] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h1C00_0204, 1'b0, 65'h0);
    // misaligned redirect: one adef entry, then fetching held off
    vt[27] = mk(1'b1, 32'h1C00_0102, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h1C00_0204, 1'b0, 65'h0);
    vt[28] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h1C00_0102, 1'b0, 65'h0);
    vt[29] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h1C00_0102, 1'b1, {1'b1, 32'h0, 32'h1C00_0102});
    vt[30] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h1C00_0102, 1'b1, {1'b1, 32'h0, 32'h1C00_0102});
    vt[31] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h1C00_0102, 1'b0, 65'h0);
    vt[32] = mk(1'b1, 32'h1C00_0300, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h1C00_0102, 1'b0, 65'h0);
    vt[33] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_0300, 1'b0, 65'h0);
    vt[34] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD0D0_0300, 1'b1, 32'h1C00_0304, 1'b0, 65'h0);
    vt[35] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1C00_0308, 1'b1, {1'b0, 32'hD0D0_0300, 32'h1C00_0300});
    vt[36] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_0308, 1'b1, {1'b0, 32'hD0D0_0300, 32'h1C00_0300});

    resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; fetch_stall = 1'b0;
    id_allowin = 1'b0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("reset", 1'b0, 32'h1C00_0000, 1'b0, 65'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      resetn            = 1'b1;
      redirect_valid    = vt[i].rv;
      redirect_pc       = vt[i].rpc;
      fetch_stall       = vt[i].st;
      id_allowin        = vt[i].al;
      inst_sram_addr_ok = vt[i].aok;
      inst_sram_data_ok = vt[i].dok;
      inst_sram_rdata   = vt[i].rd;
      #1 chk($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_valid, vt[i].e_bus);
    end

    // asynchronous reset mid-cycle with two in flight and one queued
    @(negedge clk);
    redirect_valid = 1'b0; fetch_stall = 1'b0; id_allowin = 1'b0;
    inst_sram_addr_ok = 1'b1; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    #2 resetn = 1'b0;
    #1 chk("async_rst", 1'b0, 32'h1C00_0000, 1'b0, 65'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("rst_release", 1'b1, 32'h1C00_0000, 1'b0, 65'h0);
    @(negedge clk);
    #1 chk("rst_restart", 1'b1, 32'h1C00_0004, 1'b0, 65'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
